// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the
// store-trace entry layout used by the top and the trace FIFO.
package dmem_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/dmem_trace_fifo.sv
// Store-trace FIFO with valid/ready drain and a sticky overflow flag.
// A push into a full FIFO is still taken when a pop happens on the same edge.
module dmem_trace_fifo
  import dmem_pkg::*;
#(
  parameter int TRACE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  trace_entry_t push_entry,
  input  logic         ready,
  output logic         valid,
  output trace_entry_t head,
  output logic         ovf
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TRACE_DEPTH);

  trace_entry_t  buffer [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = valid & ready;
  assign push_ok = push & (~full | pop);
  assign head    = buffer[rd_ptr];

  // Storage carries no reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) buffer[wr_ptr] <= push_entry;
  end

  // Pointers are exactly PW bits wide, so the increment wraps modulo depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data memory with completion detection and optional store trace.
// Define DMEM_RESP_TRACE_EN to build the trace FIFO; otherwise trace outputs are 0.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] DONE_ADDR   = 32'd8,
  parameter logic [31:0] DONE_VALUE  = 32'hFFFF_FFFF,
  parameter int          TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_adr,
  output logic [31:0] trace_data,
  output logic        trace_ovf
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          aligned;
  logic          store_run;
  logic          accept;
  state_t        state_q;
  state_t        state_d;

  assign word_idx = dataadr[AW+1:2];
  assign in_range = (dataadr < MEM_BYTES);
  assign aligned  = (dataadr[1:0] == 2'b00);

  // Reset gates the strobe so a store held across reset never reaches memory.
  assign store_run = reset & memwrite & (state_q == RUN);
  assign accept    = store_run & aligned & in_range;

  assign readdata = in_range ? mem[word_idx] : 32'h0;

  // NOTE: memory arrays are deliberately left out of reset so they map to RAM;
  // a reset loop over every word would force flops instead.
  always_ff @(posedge clk) begin
    if (accept) mem[word_idx] <= writedata;
  end

  // NOTE: state_d gets its default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (store_run) begin
      if (!(aligned && in_range)) begin
        state_d = FAIL;
      end else if (dataadr == DONE_ADDR) begin
        state_d = (writedata == DONE_VALUE) ? PASS : FAIL;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d != RUN);
      pass    <= (state_d == PASS);
      fail    <= (state_d == FAIL);
    end
  end

`ifdef DMEM_RESP_TRACE_EN
  trace_entry_t push_entry;
  trace_entry_t head;

  assign push_entry = '{adr: dataadr, data: writedata};

  dmem_trace_fifo #(
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_entry(push_entry),
    .ready     (trace_ready),
    .valid     (trace_valid),
    .head      (head),
    .ovf       (trace_ovf)
  );

  assign trace_adr  = head.adr;
  assign trace_data = head.data;
`else
  logic unused_trace_ready;

  assign unused_trace_ready = trace_ready;
  assign trace_valid        = 1'b0;
  assign trace_adr          = 32'h0;
  assign trace_data         = 32'h0;
  assign trace_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: completion paths, bad addresses, reset and
// the store trace (trace expectations follow DMEM_RESP_TRACE_EN).
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        done;
  logic        pass;
  logic        fail;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_adr;
  logic [31:0] trace_data;
  logic        trace_ovf;

  int total = 0;
  int bad   = 0;

  dmem_resp dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_adr  (trace_adr),
    .trace_data (trace_data),
    .trace_ovf  (trace_ovf)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    dataadr = a;
    #1 d = readdata;
  endtask

  task automatic pop();
    @(negedge clk);
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    pulse_reset();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b exp=0", fail); end
    total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", trace_valid); end
    total++; if (trace_ovf !== 1'b0) begin bad++; $display("FAIL reset_tovf got=%b exp=0", trace_ovf); end
    load(32'h1000, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_oor_load got=%h exp=0", rd); end
  endtask

  task automatic test_pass_path();
    logic [31:0] rd;
    logic [31:0] ea [2] = '{32'd84, 32'd8};
    logic [31:0] ed [2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
    pulse_reset();
    store(32'd84, 32'hFFFF_FFFE);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL pass_early_done got=%b exp=0", done); end
    store(32'd8, 32'hFFFF_FFFF);
    total++; if ({done, pass, fail} !== 3'b110) begin bad++; $display("FAIL pass_status got=%b exp=110", {done, pass, fail}); end
    load(32'd84, rd);
    total++; if (rd !== 32'hFFFF_FFFE) begin bad++; $display("FAIL pass_mem21 got=%h exp=fffffffe", rd); end
`ifdef DMEM_RESP_TRACE_EN
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({trace_valid, trace_adr, trace_data} !== {1'b1, ea[i], ed[i]}) begin
        bad++;
        $display("FAIL pass_trace%0d got=%b/%h/%h exp=1/%h/%h", i, trace_valid, trace_adr, trace_data, ea[i], ed[i]);
      end
      pop();
    end
`else
    for (int i = 0; i < 2; i++) begin
      total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL pass_notrace%0d got=%b exp=0 (%h)", i, trace_valid, ea[i] ^ ed[i]); end
      pop();
    end
`endif
    total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL pass_drained got=%b exp=0", trace_valid); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL pass_sticky got=%b exp=1", pass); end
  endtask

  task automatic test_fail_path();
    logic [31:0] rd;
    pulse_reset();
    store(32'd80, 32'hA);
    store(32'd8, 32'h5);
    total++; if ({done, pass, fail} !== 3'b101) begin bad++; $display("FAIL fail_status got=%b exp=101", {done, pass, fail}); end
    store(32'd80, 32'h7);
    load(32'd80, rd);
    total++; if (rd !== 32'hA) begin bad++; $display("FAIL fail_ignored_store got=%h exp=a", rd); end
    total++; if ({done, pass, fail} !== 3'b101) begin bad++; $display("FAIL fail_terminal got=%b exp=101", {done, pass, fail}); end
`ifdef DMEM_RESP_TRACE_EN
    total++; if ({trace_valid, trace_adr, trace_data} !== {1'b1, 32'd80, 32'hA}) begin bad++; $display("FAIL fail_trace0 got=%b/%h/%h exp=1/50/a", trace_valid, trace_adr, trace_data); end
    pop();
    total++; if ({trace_valid, trace_adr, trace_data} !== {1'b1, 32'd8, 32'h5}) begin bad++; $display("FAIL fail_trace1 got=%b/%h/%h exp=1/8/5", trace_valid, trace_adr, trace_data); end
    pop();
`endif
    total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL fail_no_extra_trace got=%b exp=0", trace_valid); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] rd;
    pulse_reset();
    store(32'd4, 32'h11);
    store(32'd6, 32'h99);
    total++; if ({done, pass, fail} !== 3'b101) begin bad++; $display("FAIL misalign_status got=%b exp=101", {done, pass, fail}); end
    load(32'd4, rd);
    total++; if (rd !== 32'h11) begin bad++; $display("FAIL misalign_nowrite got=%h exp=11", rd); end
    pulse_reset();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL bad_rerun got=%b exp=0", done); end
    store(32'd252, 32'h22);
    store(32'd256, 32'h33);
    total++; if ({done, pass, fail} !== 3'b101) begin bad++; $display("FAIL oor_status got=%b exp=101", {done, pass, fail}); end
    load(32'd256, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_load got=%h exp=0", rd); end
    load(32'd252, rd);
    total++; if (rd !== 32'h22) begin bad++; $display("FAIL top_word got=%h exp=22", rd); end
    load(32'd0, rd);
    total++; if (rd === 32'h33) begin bad++; $display("FAIL oor_alias_write got=%h exp=not 33", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] ea [4] = '{32'd20, 32'd24, 32'd28, 32'd36};
    logic [31:0] ed [4] = '{32'd2, 32'd3, 32'd4, 32'd6};
    pulse_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'd16 + 32'(4 * i), 32'(i + 1));
    total++; if (trace_ovf !== 1'b0) begin bad++; $display("FAIL ovf_at_full got=%b exp=0", trace_ovf); end
    store(32'd32, 32'd5);
`ifdef DMEM_RESP_TRACE_EN
    total++; if (trace_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", trace_ovf); end
    total++; if ({trace_valid, trace_adr, trace_data} !== {1'b1, 32'd16, 32'd1}) begin bad++; $display("FAIL ovf_head got=%b/%h/%h exp=1/10/1", trace_valid, trace_adr, trace_data); end
`else
    total++; if (trace_ovf !== 1'b0) begin bad++; $display("FAIL ovf_disabled got=%b exp=0", trace_ovf); end
`endif
    @(negedge clk);
    memwrite    = 1'b1;
    dataadr     = 32'd36;
    writedata   = 32'd6;
    trace_ready = 1'b1;
    @(negedge clk);
    memwrite    = 1'b0;
    trace_ready = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ovf_still_run got=%b exp=0", done); end
`ifdef DMEM_RESP_TRACE_EN
    total++; if (trace_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", trace_ovf); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({trace_valid, trace_adr, trace_data} !== {1'b1, ea[i], ed[i]}) begin
        bad++;
        $display("FAIL ovf_drain%0d got=%b/%h/%h exp=1/%h/%h", i, trace_valid, trace_adr, trace_data, ea[i], ed[i]);
      end
      pop();
    end
`endif
    total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", trace_valid); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    pulse_reset();
    store(32'd48, 32'h1234);
    pulse_reset();
    store(32'd40, 32'hAAAA);
    store(32'd44, 32'hBBBB);
    @(negedge clk);
    reset     = 1'b0;
    memwrite  = 1'b1;
    dataadr   = 32'd48;
    writedata = 32'hCC;
    @(negedge clk);
    reset     = 1'b1;
    memwrite  = 1'b0;
    total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", trace_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    load(32'd40, rd);
    total++; if (rd !== 32'hAAAA) begin bad++; $display("FAIL rst_mem40 got=%h exp=aaaa", rd); end
    load(32'd44, rd);
    total++; if (rd !== 32'hBBBB) begin bad++; $display("FAIL rst_mem44 got=%h exp=bbbb", rd); end
    load(32'd48, rd);
    total++; if (rd !== 32'h1234) begin bad++; $display("FAIL rst_store_ignored got=%h exp=1234", rd); end
  endtask

  initial begin
    reset       = 1'b1;
    memwrite    = 1'b0;
    dataadr     = 32'h0;
    writedata   = 32'h0;
    trace_ready = 1'b0;
    test_reset();
    test_pass_path();
    test_fail_path();
    test_bad_addr();
    test_overflow();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, 64: data memory size in 32-bit words, power of two, 4..1024.
REQ-002 Parameter DONE_ADDR, 32'd8: byte address of the completion word.
REQ-003 Parameter DONE_VALUE, 32'hFFFF_FFFF: completion value that signals pass.
REQ-004 Parameter TRACE_DEPTH, 4: store-trace FIFO entries, power of two, 2..16.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-low reset.
REQ-007 Port memwrite, input, 1: store strobe from the core.
REQ-008 Port dataadr, input, 32: byte address, used for both loads and stores.
REQ-009 Port writedata, input, 32: store data.
REQ-010 Port readdata, output, 32: load data.
REQ-011 Ports done, pass, fail, outputs, 1 each: completion status.
REQ-012 Ports trace_valid (out 1), trace_ready (in 1), trace_adr (out 32), trace_data (out 32), trace_ovf (out 1): store-trace drain port.

Function
REQ-013 readdata SHALL be combinational: mem[dataadr[log2(DEPTH)+1:2]] when in range, 32'h0 when dataadr >= DEPTH*4.
REQ-014 A store SHALL be accepted when memwrite=1, the FSM is in RUN, dataadr[1:0]=0 and dataadr < DEPTH*4. An accepted store SHALL write the word at the same rising edge.
REQ-015 The FSM SHALL have three states: RUN, PASS and FAIL. PASS and FAIL are terminal until reset.
REQ-016 In RUN, an accepted store to DONE_ADDR with writedata=DONE_VALUE SHALL move the FSM to PASS.
REQ-017 In RUN, an accepted store to DONE_ADDR with any other data SHALL move the FSM to FAIL.
REQ-018 In RUN, any store that is misaligned or out of range SHALL move the FSM to FAIL and SHALL NOT write memory.
REQ-019 Status outputs: done=1 in PASS or FAIL; pass=1 only in PASS; fail=1 only in FAIL. All are registered and assert one cycle after the triggering edge.
REQ-020 In PASS or FAIL, stores SHALL be ignored: no memory write, no trace push, no state change. Loads remain functional.
REQ-021 Each accepted store SHALL push {dataadr, writedata} into the trace FIFO, including the store that causes PASS or FAIL.
REQ-022 Trace drain uses valid/ready. An entry pops on an edge with trace_valid & trace_ready. trace_adr and trace_data SHALL hold the head entry, stable while valid=1 and ready=0.
REQ-023 Push while full with no pop SHALL drop the entry and set sticky trace_ovf.
REQ-024 Push and pop in the same cycle while full SHALL both occur, with no overflow and the count unchanged.
REQ-025 FIFO pointers SHALL wrap modulo TRACE_DEPTH. Count width is log2(TRACE_DEPTH)+1.

Reset
REQ-026 With reset=0 at a rising edge, the block SHALL enter RUN, clear done, pass and fail, empty the FIFO (trace_valid=0) and clear trace_ovf.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 A store presented during reset SHALL be ignored.
REQ-029 Reset mid-drain SHALL discard all queued entries.

Configuration
REQ-030 Macro DMEM_RESP_TRACE_EN SHALL control the trace FIFO.
REQ-031 With DMEM_RESP_TRACE_EN defined, the FIFO and REQ-021..025 SHALL be implemented.
REQ-032 Without DMEM_RESP_TRACE_EN, the ports SHALL remain. trace_valid, trace_adr, trace_data and trace_ovf SHALL be tied to 0, trace_ready is ignored, and no FIFO storage is synthesized.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the FSM state enum (RUN, PASS, FAIL) and the trace entry struct {adr[31:0], data[31:0]}.
REQ-034 The trace FIFO SHALL be sub-module dmem_trace_fifo, parameterized by TRACE_DEPTH.

Verification
REQ-035 Pass path: store 32'hFFFF_FFFE to 84, then 32'hFFFF_FFFF to 8. Required: mem[21]=FFFF_FFFE; pass=1 and done=1 one cycle after the second store; trace drains (84,FFFF_FFFE) then (8,FFFF_FFFF).
REQ-036 Fail path: store 32'h5 to 8. Required: fail=1 and done=1, pass=0. A subsequent store of 32'h7 to 80 leaves mem[20] unchanged and is not traced.
REQ-037 Bad address: store to 6 (misaligned) or to 256 with DEPTH=64. Required: FSM to FAIL, no memory write; a load from 256 returns 0.
REQ-038 Trace overflow: 5 stores with trace_ready=0 and TRACE_DEPTH=4. Required: 4 entries retained, trace_ovf=1. A 6th store with trace_ready=1 while full: no overflow change, FIFO stays full.
REQ-039 Reset mid-run: 2 stores, then reset=0 for 1 cycle. Required: trace_valid=0, done=0, and the earlier stored words still load back unchanged.
REQ-040 Build without DMEM_RESP_TRACE_EN, then repeat REQ-035. Required: pass=1, and trace_valid stays 0 throughout.
